// File: rtl/sesi_pkg.sv
// Shared constants and helpers for the switch/LED board blocks.
package sesi_pkg;

    localparam int CLK_HZ            = 100000000;
    localparam int DB_CYCLES_DEFAULT = 1000000;   // 10 ms at CLK_HZ

    // Counter width able to hold 0 .. n-1 without wrapping.
    function automatic int db_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sw_debounce_cell.sv
// One debounced switch channel: 2-flop synchroniser, persistence counter,
// accepted-level flop and registered rise/fall/toggle outputs.
module sw_debounce_cell
    import sesi_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o,
    output logic tgl_o
);

    localparam int             CW      = db_width(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          db_q,   db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic          tgl_q,  tgl_d;

    // The count only runs while the synchronised level disagrees with the
    // accepted one; any return to agreement restarts it from zero.
    always_comb begin
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        tgl_d  = tgl_q;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d   = sync2_q;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
                tgl_d  = tgl_q ^ sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: every flop here uses non-blocking assignment so the synchroniser
    // chain shifts by exactly one stage per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            tgl_q   <= 1'b0;
        end else begin
            sync1_q <= sw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tgl_q   <= tgl_d;
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign tgl_o  = tgl_q;

endmodule

// File: rtl/sw_debounce.sv
// N_SW independent switch debouncers feeding the LED blinker.
module sw_debounce
    import sesi_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int N_SW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_SW-1:0] sw,
    output logic [N_SW-1:0] sw_db,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] sw_tgl
);

    // A one-cycle window would make the counter zero bits wide.
    if (DB_CYCLES < 2) begin : g_bad_db_cycles
        $error("sw_debounce: DB_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_cell
        sw_debounce_cell #(
            .DB_CYCLES (DB_CYCLES)
        ) u_cell (
            .clk    (clk),
            .rst_n  (rst_n),
            .sw_i   (sw[i]),
            .db_o   (sw_db[i]),
            .rise_o (sw_rise[i]),
            .fall_o (sw_fall[i]),
            .tgl_o  (sw_tgl[i])
        );
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL expose parameter DB_CYCLES, default 1000000, which is the number of consecutive clocks a synchronised switch level must persist before acceptance (10 ms at 100 MHz).
REQ-002 The block SHALL expose parameter N_SW, default 8, which is the number of switch channels.
REQ-003 The block SHALL reject DB_CYCLES < 2 at elaboration.
REQ-004 Port clk SHALL be an input, 1 bit: the single system clock, rising-edge active.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port sw SHALL be an input, N_SW bits: raw board switches, asynchronous to clk and possibly bouncing.
REQ-007 Port sw_db SHALL be an output, N_SW bits: debounced, stable switch levels that drive the LED blinker's switch input.
REQ-008 Port sw_rise SHALL be an output, N_SW bits: one-clock pulse per bit when sw_db goes 0->1.
REQ-009 Port sw_fall SHALL be an output, N_SW bits: one-clock pulse per bit when sw_db goes 1->0.
REQ-010 Port sw_tgl SHALL be an output, N_SW bits: per-bit level that inverts on every sw_rise pulse.

Function
REQ-011 Each sw bit SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other logic.
REQ-012 Each bit SHALL own an unsigned counter of width $clog2(DB_CYCLES).
REQ-013 On any edge where sync2[i] == sw_db[i], counter[i] SHALL load 0.
REQ-014 On any edge where sync2[i] != sw_db[i] and counter[i] < DB_CYCLES-1, counter[i] SHALL increment by 1.
REQ-015 On any edge where sync2[i] != sw_db[i] and counter[i] == DB_CYCLES-1, sw_db[i] SHALL take sync2[i] and counter[i] SHALL load 0.
REQ-016 Counter width SHALL be such that the counter never wraps.
REQ-017 Latency: for a clean input change, sw_db SHALL update on rising edge DB_CYCLES+2, where edge 1 is the first edge that samples the new level.
REQ-018 A level at sync2 lasting fewer than DB_CYCLES edges SHALL leave sw_db unchanged.
REQ-019 Each bounce back to the accepted level SHALL restart the count from 0.
REQ-020 sw_rise[i] and sw_fall[i] SHALL be registered and asserted for exactly one cycle, on the same edge that sw_db[i] changes.
REQ-021 sw_rise[i] and sw_fall[i] SHALL never be high together.
REQ-022 sw_tgl[i] SHALL invert on the same edge that sw_rise[i] is asserted.
REQ-023 sw_tgl[i] SHALL be unaffected by falling transitions.
REQ-024 Channels SHALL be fully independent.
REQ-025 Simultaneous transitions on several bits SHALL each be handled per REQ-013..REQ-023 with no interaction between bits.
REQ-026 Every output SHALL be driven from a flop, with no combinational path from sw to any output.

Reset
REQ-027 Assertion of rst_n low SHALL immediately clear sync1, sync2, all counters, sw_db, sw_rise, sw_fall and sw_tgl to 0, regardless of clk.
REQ-028 Reset mid-count SHALL discard the partial count.
REQ-029 After reset deassertion, a switch held high SHALL produce sw_db=1 together with one sw_rise pulse after DB_CYCLES+2 edges.
REQ-030 rst_n deassertion SHALL be externally synchronised to clk; the block adds no reset synchroniser.

Structure
REQ-031 A shared package sesi_pkg SHALL hold the constants CLK_HZ = 100000000 and DB_CYCLES_DEFAULT = 1000000.
REQ-032 A shared package sesi_pkg SHALL hold the function db_width(n) returning $clog2(n).
REQ-033 Per-bit logic SHALL be a sub-module sw_debounce_cell (synchroniser, counter, stable flop, edge and toggle flops).
REQ-034 sw_debounce SHALL instantiate N_SW copies of sw_debounce_cell via a generate loop.

Verification (DB_CYCLES=4, N_SW=8)
REQ-035 Clean press: sw[0] 0->1 held -> sw_db[0]=1 and sw_rise[0]=1 for one cycle on edge 6, sw_tgl[0]=1, all other outputs 0.
REQ-036 Bounce: sw[1] sequence 1,0,1,0 each held 2 cycles, then 1 held -> sw_db[1] rises once, 6 edges after the final 0->1, exactly one sw_rise[1] pulse.
REQ-037 Glitch: sw[2] high for 3 cycles, then low -> sw_db[2], sw_rise[2] and sw_tgl[2] stay 0 throughout.
REQ-038 Reset mid-count: sw[3]=1, rst_n low for 1 cycle at edge 4, released -> all outputs 0 during reset, sw_db[3]=1 exactly 6 edges after the first post-reset edge.
REQ-039 Simultaneous: sw=8'hFF from 8'h00 -> sw_db=8'hFF and sw_rise=8'hFF for one cycle on edge 6; later sw=8'h00 -> sw_fall=8'hFF for one cycle, sw_tgl remains 8'hFF.
REQ-040 Double press: two clean presses on sw[4] -> sw_tgl[4] goes 1 then 0, with 2 sw_rise[4] and 2 sw_fall[4] pulses.
